// File: rtl/reg_file_wb.sv
// Write-back register bank: R0..R7 behind a one-entry write-pending stage.
// Define REG_FILE_BYPASS_EN to forward pending data to the read ports.
module reg_file_wb #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_We,
  input  logic [ADDR_W-1:0] i_Addr_W,
  input  logic [DATA_W-1:0] i_DW,
  input  logic [ADDR_W-1:0] i_Addr_Y,
  input  logic [ADDR_W-1:0] i_Addr_Z,
  output logic [DATA_W-1:0] o_R0,
  output logic [DATA_W-1:0] o_Ry,
  output logic [DATA_W-1:0] o_Rz,
  output logic              o_Wr_Pend,
  output logic              o_Zero,
  output logic [CNT_W-1:0]  o_Wr_Cnt
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [NREG];
  logic              r_pend_valid;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [DATA_W-1:0] r_pend_data;
  logic              r_zero;
  logic [CNT_W-1:0]  r_cnt;

  logic [DATA_W-1:0] w_ry;
  logic [DATA_W-1:0] w_rz;
  logic [DATA_W-1:0] w_r0;

  // Capture and commit share one edge, so back-to-back writes flow at 1/cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_data  <= '0;
      r_zero       <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_pend_valid <= i_We;
      if (i_We) begin
        r_pend_addr <= i_Addr_W;
        r_pend_data <= i_DW;
      end
      if (r_pend_valid) begin
        r_mem[r_pend_addr] <= r_pend_data;
        r_cnt              <= r_cnt + CNT_W'(1);
        r_zero             <= (r_pend_data == '0);
      end
    end
  end

`ifdef REG_FILE_BYPASS_EN
  always_comb begin
    w_ry = r_mem[i_Addr_Y];
    w_rz = r_mem[i_Addr_Z];
    w_r0 = r_mem[0];
    if (r_pend_valid && (r_pend_addr == i_Addr_Y)) begin
      w_ry = r_pend_data;
    end
    if (r_pend_valid && (r_pend_addr == i_Addr_Z)) begin
      w_rz = r_pend_data;
    end
    if (r_pend_valid && (r_pend_addr == '0)) begin
      w_r0 = r_pend_data;
    end
  end
`else
  always_comb begin
    w_ry = r_mem[i_Addr_Y];
    w_rz = r_mem[i_Addr_Z];
    w_r0 = r_mem[0];
  end
`endif

  assign o_Ry      = w_ry;
  assign o_Rz      = w_rz;
  assign o_R0      = w_r0;
  assign o_Wr_Pend = r_pend_valid;
  assign o_Zero    = r_zero;
  assign o_Wr_Cnt  = r_cnt;

endmodule
